// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: BCD digits, UI field enables in, 7-seg drive out.
// master = the UI/clock side, slave = the scan driver.
interface seg_scan_driver_if;
    logic [7:0] i_time_hr;
    logic [7:0] i_time_min;
    logic [7:0] i_alarm_hr;
    logic [7:0] i_alarm_min;
    logic       i_adjust;
    logic       i_en_th;
    logic       i_en_tm;
    logic       i_en_ah;
    logic       i_en_am;
    logic       i_alarm_armed;
    logic [6:0] o_segments;
    logic [3:0] o_anode_active;
    logic       o_dp;

    modport master (
        output i_time_hr, i_time_min, i_alarm_hr, i_alarm_min,
        output i_adjust, i_en_th, i_en_tm, i_en_ah, i_en_am, i_alarm_armed,
        input  o_segments, o_anode_active, o_dp
    );

    modport slave (
        input  i_time_hr, i_time_min, i_alarm_hr, i_alarm_min,
        input  i_adjust, i_en_th, i_en_tm, i_en_ah, i_en_am, i_alarm_armed,
        output o_segments, o_anode_active, o_dp
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner: one digit per refresh tick, field blink,
// leading-zero suppression on hour tens, alarm-armed flag on digit 2's decimal point.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 250000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg_scan_driver_if.slave   bus
);
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [6:0]    r_segments;
    logic [3:0]    r_anode;
    logic          r_dp;

    logic          w_tick;
    logic          w_blink_wrap;
    logic [1:0]    w_nidx;
    logic          w_fld_hr;
    logic          w_fld_min;
    logic          w_alarm_src;
    logic [7:0]    w_hr;
    logic [7:0]    w_min;
    logic [3:0]    w_nibble;
    logic          w_in_field;
    logic          w_lead_zero;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;
    logic          w_dp_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign w_tick       = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));
    assign w_nidx       = r_idx + 2'd1;

    // The highest-priority enable decides both the blinking field and the digit source,
    // so an hours edit never shows alarm digits just because an alarm enable is also up.
    always_comb begin
        w_fld_hr    = 1'b0;
        w_fld_min   = 1'b0;
        w_alarm_src = 1'b0;
        if (bus.i_adjust) begin
            if (bus.i_en_th) begin
                w_fld_hr = 1'b1;
            end else if (bus.i_en_tm) begin
                w_fld_min = 1'b1;
            end else if (bus.i_en_ah) begin
                w_fld_hr    = 1'b1;
                w_alarm_src = 1'b1;
            end else if (bus.i_en_am) begin
                w_fld_min   = 1'b1;
                w_alarm_src = 1'b1;
            end
        end
    end

    assign w_hr  = w_alarm_src ? bus.i_alarm_hr  : bus.i_time_hr;
    assign w_min = w_alarm_src ? bus.i_alarm_min : bus.i_time_min;

    always_comb begin
        w_nibble = 4'd0;
        case (w_nidx)
            2'd0: w_nibble = w_min[3:0];
            2'd1: w_nibble = w_min[7:4];
            2'd2: w_nibble = w_hr[3:0];
            2'd3: w_nibble = w_hr[7:4];
            default: w_nibble = 4'd0;
        endcase
    end

    assign w_in_field  = w_nidx[1] ? w_fld_hr : w_fld_min;
    assign w_lead_zero = (w_nidx == 2'd3) && (w_hr[7:4] == 4'd0) && !bus.i_adjust;
    assign w_blank     = (r_blink_phase && w_in_field) || w_lead_zero;
    assign w_seg_nxt   = w_blank ? SEG_OFF : seg7(w_nibble);
    assign w_an_nxt    = ~(4'b0001 << w_nidx);
    assign w_dp_nxt    = !((w_nidx == 2'd2) && bus.i_alarm_armed);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd3;
        end else if (w_tick) begin
            r_scan_cnt <= '0;
            r_idx      <= w_nidx;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    // Leaving adjust mode parks the blink at the visible phase so re-entry starts lit.
    always_ff @(posedge i_clk) begin
        if (!i_rst || !bus.i_adjust) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_wrap) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_segments <= SEG_OFF;
            r_anode    <= 4'b1111;
            r_dp       <= 1'b1;
        end else if (w_tick) begin
            r_segments <= w_seg_nxt;
            r_anode    <= w_an_nxt;
            r_dp       <= w_dp_nxt;
        end
    end

    assign bus.o_segments     = r_segments;
    assign bus.o_anode_active = r_anode;
    assign bus.o_dp           = r_dp;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=8; expected values are hand-derived.
module tb_seg_scan_driver;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seg_scan_driver_if u_if ();

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(8)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        chk({tag, ".an"},  32'(u_if.o_anode_active), 32'(an));
        chk({tag, ".seg"}, 32'(u_if.o_segments),     32'(seg));
        chk({tag, ".dp"},  32'(u_if.o_dp),           32'(dp));
    endtask

    task automatic tick_chk(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        repeat (4) @(posedge clk);
        #1;
        chk_out(tag, an, seg, dp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_in(input logic [7:0] th, input logic [7:0] tm, input logic [7:0] ah,
                          input logic [7:0] am, input logic adj, input logic [3:0] en, input logic arm);
        u_if.i_time_hr    = th;
        u_if.i_time_min   = tm;
        u_if.i_alarm_hr   = ah;
        u_if.i_alarm_min  = am;
        u_if.i_adjust     = adj;
        {u_if.i_en_th, u_if.i_en_tm, u_if.i_en_ah, u_if.i_en_am} = en;
        u_if.i_alarm_armed = arm;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        set_in(8'h12, 8'h45, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b0);

        // reset hold, then dark for three cycles, first tick shows digit 0
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst_hold", 4'b1111, SB, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("rst_dark%0d", i), 4'b1111, SB, 1'b1);
        end
        @(posedge clk);
        #1;
        chk_out("first_tick", 4'b1110, S5, 1'b1);

        // full scan of 12:07 with hold check between ticks
        set_in(8'h12, 8'h07, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b0);
        do_reset();
        tick_chk("scan_d0", 4'b1110, S7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("scan_hold%0d", i), 4'b1110, S7, 1'b1);
        end
        @(posedge clk);
        #1;
        chk_out("scan_d1", 4'b1101, S0, 1'b1);
        tick_chk("scan_d2", 4'b1011, S2, 1'b1);
        tick_chk("scan_d3", 4'b0111, S1, 1'b1);
        tick_chk("scan_wrap", 4'b1110, S7, 1'b1);

        // leading-zero suppression and alarm-armed dp
        set_in(8'h09, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1);
        do_reset();
        tick_chk("lz_d0", 4'b1110, S0, 1'b1);
        tick_chk("lz_d1", 4'b1101, S0, 1'b1);
        tick_chk("lz_d2", 4'b1011, S9, 1'b0);
        tick_chk("lz_d3", 4'b0111, SB, 1'b1);

        // alarm source 06:30 while editing alarm minutes, blink still in visible phase
        set_in(8'h11, 8'h11, 8'h06, 8'h30, 1'b1, 4'b0001, 1'b0);
        do_reset();
        tick_chk("am_d0", 4'b1110, S0, 1'b1);
        tick_chk("am_d1", 4'b1101, S3, 1'b1);
        tick_chk("am_d2", 4'b1011, S6, 1'b1);
        tick_chk("am_d3", 4'b0111, S0, 1'b1);

        // enter adjust after two slots so the blank half-period lands on digits 1,0
        set_in(8'h11, 8'h11, 8'h06, 8'h30, 1'b0, 4'b0000, 1'b0);
        do_reset();
        tick_chk("amb_pre0", 4'b1110, S1, 1'b1);
        tick_chk("amb_pre1", 4'b1101, S1, 1'b1);
        set_in(8'h11, 8'h11, 8'h06, 8'h30, 1'b1, 4'b0001, 1'b0);
        tick_chk("amb_d2", 4'b1011, S6, 1'b1);
        tick_chk("amb_d3", 4'b0111, S0, 1'b1);
        tick_chk("amb_d0", 4'b1110, SB, 1'b1);
        tick_chk("amb_d1", 4'b1101, SB, 1'b1);
        tick_chk("amb_d2b", 4'b1011, S6, 1'b1);
        tick_chk("amb_d3b", 4'b0111, S0, 1'b1);

        // en_th beats en_am: time source, dash on bad BCD, only hours blink
        set_in(8'h1C, 8'h34, 8'h06, 8'h30, 1'b0, 4'b1001, 1'b0);
        do_reset();
        tick_chk("pri_d0", 4'b1110, S4, 1'b1);
        u_if.i_adjust = 1'b1;
        tick_chk("pri_d1", 4'b1101, S3, 1'b1);
        tick_chk("pri_d2", 4'b1011, SD, 1'b1);
        tick_chk("pri_d3", 4'b0111, SB, 1'b1);
        tick_chk("pri_d0b", 4'b1110, S4, 1'b1);
        tick_chk("pri_d1b", 4'b1101, S3, 1'b1);
        tick_chk("pri_d2b", 4'b1011, SD, 1'b1);
        tick_chk("pri_d3b", 4'b0111, SB, 1'b1);

        // reset while digit 2 is blank in the blink phase; dp is unaffected by blink
        set_in(8'h1C, 8'h34, 8'h06, 8'h30, 1'b1, 4'b1001, 1'b1);
        do_reset();
        tick_chk("mid_d0", 4'b1110, S4, 1'b1);
        tick_chk("mid_d1", 4'b1101, S3, 1'b1);
        tick_chk("mid_d2", 4'b1011, SB, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("mid_rst", 4'b1111, SB, 1'b1);
        rst = 1'b1;
        tick_chk("mid_re_d0", 4'b1110, S4, 1'b1);
        tick_chk("mid_re_d1", 4'b1101, S3, 1'b1);
        tick_chk("mid_re_d2", 4'b1011, SB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
